// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage and the control unit.
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  // sll $0,$0,0: decodes as an R-type write to $0, which has no effect.
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    BEQ   = 6'b000100,
    LW    = 6'b100011,
    SW    = 6'b101011
  } opcode_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] incrPc(input logic [31:0] cur);
    return cur + 32'd4;
  endfunction

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter with synchronous reset, redirect load, hold and +4 increment.
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] loadAddr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4
);

  logic [31:0] pcReg;

  // PC update: reset, then redirect load (wins over hold), then hold, else advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcReg <= RESET_PC;
    end else if (load) begin
      pcReg <= alignWord(loadAddr);
    end else if (!hold) begin
      pcReg <= incrPc(pcReg);
    end
  end

  assign pc      = pcReg;
  assign pcPlus4 = incrPc(pcReg);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory address, IF/ID latch and fetch counter.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic [31:0] fetch_count
);

  logic [31:0] pcCur;
  logic [31:0] pcNext4;
  logic [31:0] ifIdInstr;
  logic [31:0] ifIdPcPlus4;
  logic        ifIdValid;
  logic [31:0] fetchCnt;
  opcode_e     opcodeField;

  // ---- IF: PC and instruction-memory address ----
  pc_register #(
    .RESET_PC (RESET_PC)
  ) uPcRegister (
    .clk      (clk),
    .reset    (reset),
    .hold     (stall),
    .load     (branch_taken),
    .loadAddr (branch_target),
    .pc       (pcCur),
    .pcPlus4  (pcNext4)
  );

  assign pc        = pcCur;
  assign imem_addr = pcCur;

  // ---- IF/ID boundary ----
  // IF/ID latch and fetch counter: a redirect flushes the wrong-path word without counting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ifIdInstr   <= NOP_INSTR;
      ifIdPcPlus4 <= 32'd0;
      ifIdValid   <= 1'b0;
      fetchCnt    <= 32'd0;
    end else if (branch_taken) begin
      ifIdInstr   <= NOP_INSTR;
      ifIdPcPlus4 <= 32'd0;
      ifIdValid   <= 1'b0;
    end else if (!stall) begin
      ifIdInstr   <= imem_rdata;
      ifIdPcPlus4 <= pcNext4;
      ifIdValid   <= 1'b1;
      fetchCnt    <= fetchCnt + 32'd1;
    end
  end

  assign opcodeField    = opcode_e'(ifIdInstr[OPC_HI:OPC_LO]);
  assign opcode         = opcodeField;
  assign if_id_instr    = ifIdInstr;
  assign if_id_pc_plus4 = ifIdPcPlus4;
  assign if_id_valid    = ifIdValid;
  assign fetch_count    = fetchCnt;

endmodule
